// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and ROM fetch initiator feeding the IF/ID register,
// with stall, branch/flush redirect and misaligned-target fault handling.
module inst_fetch #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_pc_i,
   input  logic [INST_W-1:0] inst_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_valid_o,
   output logic              misalign_o
);
   typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
   state_t state;
   logic [ADDR_W-1:0] pc, tgt;
   logic redir, tgt_mis;
   assign tgt = flush_i ? flush_pc_i : branch_pc_i;
   assign redir = flush_i | branch_i;
   assign tgt_mis = |tgt[1:0];
   assign rom_addr_o = pc;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         rom_ce_o <= 1'b0;
         id_pc_o <= '0;
         id_inst_o <= NOP_INST;
         id_valid_o <= 1'b0;
         misalign_o <= 1'b0;
      end else
         case (state)
            IDLE:
               if (redir && tgt_mis) begin
                  state <= FAULT;
                  pc <= tgt;
                  misalign_o <= 1'b1;
               end else begin
                  state <= FETCH;
                  rom_ce_o <= 1'b1;
                  if (redir) pc <= tgt;
               end
            FETCH:
               if (redir) begin
                  pc <= tgt;
                  id_pc_o <= tgt;
                  id_inst_o <= NOP_INST;
                  id_valid_o <= 1'b0;
                  if (tgt_mis) begin
                     state <= FAULT;
                     rom_ce_o <= 1'b0;
                     misalign_o <= 1'b1;
                  end
               end else if (!stall_i) begin
                  id_pc_o <= pc;
                  id_inst_o <= inst_i;
                  id_valid_o <= 1'b1;
                  pc <= pc + ADDR_W'(4);
               end
            FAULT:
               // only an exception flush can leave the fault; a misaligned one re-faults
               if (flush_i) begin
                  pc <= flush_pc_i;
                  if (~|flush_pc_i[1:0]) begin
                     state <= FETCH;
                     rom_ce_o <= 1'b1;
                     misalign_o <= 1'b0;
                  end
               end
            default: state <= IDLE;
         endcase
endmodule
